// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the instruction encoder slice.
// Contents:
//   opcode_t    - RV32I base opcodes understood by the encoder
//   insn_fmt_t  - instruction encoding formats (R/I/S/B/U/J)
//   F7_DEFAULT / F7_ALT - the two legal funct7 values for OP / shift-immediate
//   NOP_INSN    - canonical NOP (ADDI x0,x0,0)
package rv32i_pkg;

    typedef enum logic [6:0] {
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BRANCH = 7'b1100011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_I_TYPE = 7'b0010011,
        OP_R_TYPE = 7'b0110011,
        OP_SYSTEM = 7'b1110011
    } opcode_t;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J
    } insn_fmt_t;

    localparam logic [6:0]  F7_DEFAULT = 7'b0000000;
    localparam logic [6:0]  F7_ALT     = 7'b0100000;
    localparam logic [31:0] NOP_INSN   = 32'h0000_0013;

endpackage

// File: rtl/rv32i_insn_encoder_if.sv
// Field-bundle input and IMEM write port of the RV32I instruction encoder.
// Signals:
//   in_valid/in_ready           - bundle handshake (accept when both high)
//   in_opcode..in_imm           - instruction fields to pack
//   wr_en/wr_ready              - IMEM write handshake (commit when both high)
//   wr_addr/wr_data             - word address and encoded instruction
// Modports:
//   master - the encoder (consumes bundles, drives the write port)
//   slave  - the environment (program source and IMEM)
interface rv32i_insn_encoder_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic              in_ready;
    logic [6:0]        in_opcode;
    logic [2:0]        in_funct3;
    logic [6:0]        in_funct7;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [31:0]       in_imm;
    logic              wr_en;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;

    modport master (
        input  in_valid, in_opcode, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm,
        output in_ready,
        output wr_en, wr_addr, wr_data,
        input  wr_ready
    );

    modport slave (
        output in_valid, in_opcode, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm,
        input  in_ready,
        input  wr_en, wr_addr, wr_data,
        output wr_ready
    );
endinterface

// File: rtl/rv32i_insn_pack.sv
// Combinational RV32I field packer: fields -> {format, 32-bit word, illegal}.
// Ports:
//   opcode, funct3, funct7, rd, rs1, rs2, imm - instruction fields
//   fmt     - encoding format selected by opcode (unknown opcodes pack as R)
//   word    - packed instruction
//   illegal - bundle violates RV32I encoding rules
// Build option: RV32I_ENC_CHECK_EN enables the legality checks; without it
// illegal is constant 0 and every bundle is packed.
module rv32i_insn_pack
    import rv32i_pkg::*;
(
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output insn_fmt_t   fmt,
    output logic [31:0] word,
    output logic        illegal
);
    // SLLI/SRLI/SRAI (funct3 001/101) carry funct7 in the upper immediate field.
    logic is_shift;
    assign is_shift = (opcode == OP_I_TYPE) && (funct3[1:0] == 2'b01);

    always_comb begin
        // NOTE: assign a default first so every path drives the output and no latch is inferred.
        fmt = FMT_R;
        case (opcode)
            OP_LUI, OP_AUIPC:                      fmt = FMT_U;
            OP_JAL:                                fmt = FMT_J;
            OP_JALR, OP_LOAD, OP_I_TYPE, OP_SYSTEM: fmt = FMT_I;
            OP_STORE:                              fmt = FMT_S;
            OP_BRANCH:                             fmt = FMT_B;
            default:                               fmt = FMT_R;
        endcase
    end

    always_comb begin
        word = {funct7, rs2, rs1, funct3, rd, opcode};
        case (fmt)
            FMT_I: word = is_shift ? {funct7, imm[4:0], rs1, funct3, rd, opcode}
                                   : {imm[11:0], rs1, funct3, rd, opcode};
            FMT_S: word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            FMT_B: word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            FMT_U: word = {imm[31:12], rd, opcode};
            FMT_J: word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            default: ;
        endcase
    end

`ifdef RV32I_ENC_CHECK_EN
    logic f7_ok;
    assign f7_ok = (funct7 == F7_DEFAULT) || (funct7 == F7_ALT);

    always_comb begin
        illegal = 1'b0;
        case (opcode)
            OP_BRANCH: illegal = (funct3 == 3'b010) || (funct3 == 3'b011) || imm[0];
            OP_LOAD:   illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
            OP_STORE:  illegal = (funct3 > 3'b010);
            OP_R_TYPE: illegal = !f7_ok ||
                                 ((funct7 == F7_ALT) && (funct3 != 3'b000) && (funct3 != 3'b101));
            OP_I_TYPE: illegal = ((funct3 == 3'b001) && (funct7 != F7_DEFAULT)) ||
                                 ((funct3 == 3'b101) && !f7_ok);
            OP_JAL:    illegal = imm[0];
            OP_LUI, OP_AUIPC, OP_JALR, OP_SYSTEM: illegal = 1'b0;
            default:   illegal = 1'b1;
        endcase
    end
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: rtl/rv32i_insn_encoder.sv
// RV32I instruction encoder: accepts field bundles, packs them into RV32I
// words and streams them to IMEM at sequential word addresses.
// Ports:
//   clk, rst     - clock and synchronous active-high reset
//   start        - restart at BASE_ADDR, drop any pending word, clear full
//   bus          - bundle input and IMEM write port (master modport)
//   full         - DEPTH words committed since start/reset
//   err_illegal  - one-cycle pulse after an accepted bundle was rejected
//   insn_count   - words committed since start/reset
// Build option: RV32I_ENC_CHECK_EN (legality checking inside rv32i_insn_pack).
module rv32i_insn_encoder
    import rv32i_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int DEPTH     = 1024,
    parameter int BASE_ADDR = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    rv32i_insn_encoder_if.master bus,
    output logic                 full,
    output logic                 err_illegal,
    output logic [ADDR_W:0]      insn_count
);
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W+1)'(DEPTH);

    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [31:0]       wr_data_q;

    // The packer's format output is informational; the word already reflects it.
    insn_fmt_t   unused_fmt;
    logic [31:0] word;
    logic        illegal;

    rv32i_insn_pack u_pack (
        .opcode  (bus.in_opcode),
        .funct3  (bus.in_funct3),
        .funct7  (bus.in_funct7),
        .rd      (bus.in_rd),
        .rs1     (bus.in_rs1),
        .rs2     (bus.in_rs2),
        .imm     (bus.in_imm),
        .fmt     (unused_fmt),
        .word    (word),
        .illegal (illegal)
    );

    logic            in_ready;
    logic            accept;
    logic            commit;
    logic [ADDR_W:0] count_inc;

    // A commit frees the output register in the same cycle, so the next bundle
    // can be taken without a bubble.
    assign in_ready  = !full && !start && (!wr_en_q || bus.wr_ready);
    assign accept    = bus.in_valid && in_ready;
    assign commit    = wr_en_q && bus.wr_ready;
    assign count_inc = insn_count + (ADDR_W+1)'(1);

    assign bus.in_ready = in_ready;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_q     <= 1'b0;
            wr_addr_q   <= BASE;
            wr_data_q   <= '0;
            full        <= 1'b0;
            err_illegal <= 1'b0;
            insn_count  <= '0;
        end else if (start) begin
            // Pending word is dropped; wr_en falls even if IMEM is ready now.
            wr_en_q     <= 1'b0;
            wr_addr_q   <= BASE;
            full        <= 1'b0;
            err_illegal <= 1'b0;
            insn_count  <= '0;
        end else begin
            err_illegal <= accept && illegal;

            if (accept && !illegal) begin
                wr_en_q   <= 1'b1;
                wr_data_q <= word;
            end else if (commit) begin
                wr_en_q <= 1'b0;
            end

            if (commit) begin
                insn_count <= count_inc;
                // Address stays on the last written word once full: no wrap.
                if (count_inc == DEPTH_CNT) begin
                    full <= 1'b1;
                end else begin
                    wr_addr_q <= wr_addr_q + ADDR_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_rv32i_insn_encoder.sv
// Self-checking bench for rv32i_insn_encoder: directed vectors from the
// encoding rules followed by randomized traffic scored against a
// behavioural model (arithmetic field packing, queue of pending words).
module tb_rv32i_insn_encoder;
    import rv32i_pkg::*;

    localparam int ADDR_W    = 4;
    localparam int DEPTH     = 4;
    localparam int BASE_ADDR = 3;

`ifdef RV32I_ENC_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            full;
    logic            err_illegal;
    logic [ADDR_W:0] insn_count;

    rv32i_insn_encoder_if #(.ADDR_W(ADDR_W)) bus ();

    rv32i_insn_encoder #(
        .ADDR_W    (ADDR_W),
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE_ADDR)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .bus         (bus),
        .full        (full),
        .err_illegal (err_illegal),
        .insn_count  (insn_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_bad    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] pend_q[$];
    int          m_count;
    bit          m_full;
    bit          m_err;
    logic [31:0] m_data;

    function automatic logic [31:0] fld(input logic [31:0] v, input int lo, input int w);
        return (v >> lo) & ((32'h1 << w) - 32'h1);
    endfunction

    function automatic logic [31:0] encode(input logic [6:0] op, input logic [2:0] f3,
                                           input logic [6:0] f7, input logic [4:0] rd,
                                           input logic [4:0] rs1, input logic [4:0] rs2,
                                           input logic [31:0] imm);
        logic [31:0] o, a3, a7, d, s1, s2;
        o = 32'(op); a3 = 32'(f3); a7 = 32'(f7); d = 32'(rd); s1 = 32'(rs1); s2 = 32'(rs2);
        case (op)
            OP_LUI, OP_AUIPC:
                return (imm & 32'hFFFF_F000) | (d << 7) | o;
            OP_JAL:
                return (fld(imm, 20, 1) << 31) | (fld(imm, 1, 10) << 21) | (fld(imm, 11, 1) << 20) |
                       (fld(imm, 12, 8) << 12) | (d << 7) | o;
            OP_BRANCH:
                return (fld(imm, 12, 1) << 31) | (fld(imm, 5, 6) << 25) | (s2 << 20) | (s1 << 15) |
                       (a3 << 12) | (fld(imm, 1, 4) << 8) | (fld(imm, 11, 1) << 7) | o;
            OP_STORE:
                return (fld(imm, 5, 7) << 25) | (s2 << 20) | (s1 << 15) | (a3 << 12) |
                       (fld(imm, 0, 5) << 7) | o;
            OP_JALR, OP_LOAD, OP_SYSTEM, OP_I_TYPE: begin
                if (op == OP_I_TYPE && (f3 == 3'd1 || f3 == 3'd5))
                    return (a7 << 25) | (fld(imm, 0, 5) << 20) | (s1 << 15) | (a3 << 12) | (d << 7) | o;
                return (fld(imm, 0, 12) << 20) | (s1 << 15) | (a3 << 12) | (d << 7) | o;
            end
            default:
                return (a7 << 25) | (s2 << 20) | (s1 << 15) | (a3 << 12) | (d << 7) | o;
        endcase
    endfunction

    function automatic bit rule_illegal(input logic [6:0] op, input logic [2:0] f3,
                                        input logic [6:0] f7, input logic [31:0] imm);
        bit f7_ok;
        f7_ok = (f7 == 7'h00) || (f7 == 7'h20);
        case (op)
            OP_BRANCH: return (f3 inside {3'd2, 3'd3}) || imm[0];
            OP_LOAD:   return f3 inside {3'd3, 3'd6, 3'd7};
            OP_STORE:  return f3 > 3'd2;
            OP_R_TYPE: return !f7_ok || (f7 == 7'h20 && !(f3 inside {3'd0, 3'd5}));
            OP_I_TYPE: return (f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && !f7_ok);
            OP_JAL:    return imm[0];
            OP_LUI, OP_AUIPC, OP_JALR, OP_SYSTEM: return 1'b0;
            default:   return 1'b1;
        endcase
    endfunction

    function automatic bit exp_in_ready();
        return !m_full && !start && (pend_q.size() == 0 || bus.wr_ready);
    endfunction

    task automatic compare_all();
        check("in_ready", 32'(bus.in_ready), 32'(exp_in_ready()));
        check("wr_en", 32'(bus.wr_en), 32'(pend_q.size() != 0));
        check("wr_data", bus.wr_data, m_data);
        check("full", 32'(full), 32'(m_full));
        check("insn_count", 32'(insn_count), 32'(m_count));
        check("err_illegal", 32'(err_illegal), 32'(m_err));
        if (!m_full)
            check("wr_addr", 32'(bus.wr_addr), (BASE_ADDR + m_count) % (1 << ADDR_W));
    endtask

    // Called just after the rising edge; reads only bench-driven inputs.
    task automatic update_model();
        bit          acc, commit;
        logic [31:0] w;
        acc    = bus.in_valid && exp_in_ready();
        commit = (pend_q.size() != 0) && bus.wr_ready;
        if (rst) begin
            pend_q.delete();
            m_count = 0; m_full = 0; m_err = 0; m_data = '0;
        end else if (start) begin
            pend_q.delete();
            m_count = 0; m_full = 0; m_err = 0;
        end else begin
            m_err = 0;
            if (commit) begin
                void'(pend_q.pop_front());
                m_count++;
                if (m_count == DEPTH) m_full = 1;
            end
            if (acc) begin
                if (CHECK_EN && rule_illegal(bus.in_opcode, bus.in_funct3, bus.in_funct7, bus.in_imm)) begin
                    m_err = 1;
                end else begin
                    w = encode(bus.in_opcode, bus.in_funct3, bus.in_funct7, bus.in_rd,
                               bus.in_rs1, bus.in_rs2, bus.in_imm);
                    pend_q.push_back(w);
                    m_data = w;
                end
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic cycle();
        #1 compare_all();
        @(posedge clk);
        update_model();
        @(negedge clk);
    endtask

    task automatic idle(input bit rdy);
        bus.in_valid = 1'b0;
        bus.wr_ready = rdy;
        rst          = 1'b0;
        start        = 1'b0;
    endtask

    task automatic offer(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] imm, input bit rdy);
        bus.in_valid  = 1'b1;
        bus.in_opcode = op;
        bus.in_funct3 = f3;
        bus.in_funct7 = f7;
        bus.in_rd     = rd;
        bus.in_rs1    = rs1;
        bus.in_rs2    = rs2;
        bus.in_imm    = imm;
        bus.wr_ready  = rdy;
        rst           = 1'b0;
        start         = 1'b0;
    endtask

    task automatic do_start();
        idle(1'b1);
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    logic [6:0] op_tab[10] = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
                               OP_LOAD, OP_STORE, OP_I_TYPE, OP_R_TYPE, OP_SYSTEM};

    initial begin
        rst = 1'b1; start = 1'b0;
        bus.in_valid = 1'b0; bus.wr_ready = 1'b0;
        bus.in_opcode = '0; bus.in_funct3 = '0; bus.in_funct7 = '0;
        bus.in_rd = '0; bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_imm = '0;
        repeat (2) begin
            @(posedge clk);
            update_model();
        end
        @(negedge clk);

        // Reset state
        idle(1'b1);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_wr_en", 32'(bus.wr_en), 32'd0);
        check("rst_wr_addr", 32'(bus.wr_addr), 32'(BASE_ADDR));
        check("rst_wr_data", bus.wr_data, 32'h0);
        check("rst_count", 32'(insn_count), 32'd0);
        cycle();

        // ADD x3,x1,x2
        offer(OP_R_TYPE, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1);
        cycle();
        idle(1'b1);
        #1;
        check("add_wr_en", 32'(bus.wr_en), 32'd1);
        check("add_data", bus.wr_data, 32'h002081B3);
        check("add_addr", 32'(bus.wr_addr), 32'(BASE_ADDR));
        cycle();
        do_start();

        // ADDI x1,x0,-1 then SW x5,4(x2) back-to-back
        offer(OP_I_TYPE, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b1);
        cycle();
        offer(OP_STORE, 3'd2, 7'd0, 5'd0, 5'd2, 5'd5, 32'd4, 1'b1);
        #1;
        check("addi_data", bus.wr_data, 32'hFFF00093);
        check("addi_addr", 32'(bus.wr_addr), 32'(BASE_ADDR));
        check("b2b_in_ready", 32'(bus.in_ready), 32'd1);
        cycle();
        idle(1'b1);
        #1;
        check("sw_wr_en", 32'(bus.wr_en), 32'd1);
        check("sw_data", bus.wr_data, 32'h00512223);
        check("sw_addr", 32'(bus.wr_addr), 32'(BASE_ADDR + 1));
        cycle();
        do_start();

        // BEQ x1,x2,+8 ; JAL x1,+2048
        offer(OP_BRANCH, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b1);
        cycle();
        idle(1'b1);
        #1 check("beq_data", bus.wr_data, 32'h00208463);
        cycle();
        offer(OP_JAL, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b1);
        cycle();
        idle(1'b1);
        #1 check("jal_data", bus.wr_data, 32'h001000EF);
        cycle();
        do_start();

        // Backpressure: three stalled cycles, commit on the fourth
        offer(OP_R_TYPE, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
        cycle();
        for (int k = 0; k < 3; k++) begin
            offer(OP_LUI, 3'd0, 7'd0, 5'd7, 5'd0, 5'd0, 32'h1234_5000, 1'b0);
            #1;
            check("stall_data", bus.wr_data, 32'h002081B3);
            check("stall_addr", 32'(bus.wr_addr), 32'(BASE_ADDR));
            check("stall_in_ready", 32'(bus.in_ready), 32'd0);
            cycle();
        end
        idle(1'b1);
        #1 check("stall_wr_en", 32'(bus.wr_en), 32'd1);
        cycle();
        idle(1'b1);
        #1;
        check("stall_count", 32'(insn_count), 32'd1);
        check("stall_done", 32'(bus.wr_en), 32'd0);
        cycle();
        do_start();

        // Fill to DEPTH, then restart
        for (int k = 0; k < DEPTH; k++) begin
            offer(OP_R_TYPE, 3'd0, 7'd0, 5'(k + 1), 5'd1, 5'd2, 32'd0, 1'b1);
            cycle();
        end
        idle(1'b1);
        cycle();
        offer(OP_R_TYPE, 3'd0, 7'd0, 5'd9, 5'd1, 5'd2, 32'd0, 1'b1);
        #1;
        check("full_flag", 32'(full), 32'd1);
        check("full_in_ready", 32'(bus.in_ready), 32'd0);
        check("full_count", 32'(insn_count), 32'(DEPTH));
        cycle();
        idle(1'b1);
        #1 check("full_no_write", 32'(bus.wr_en), 32'd0);
        do_start();
        idle(1'b1);
        #1;
        check("restart_addr", 32'(bus.wr_addr), 32'(BASE_ADDR));
        check("restart_count", 32'(insn_count), 32'd0);
        check("restart_full", 32'(full), 32'd0);
        cycle();

        // Branch with reserved funct3 010
        offer(OP_BRANCH, 3'b010, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b1);
        cycle();
        idle(1'b1);
        #1;
        check("illegal_err", 32'(err_illegal), 32'(CHECK_EN));
        check("illegal_wr_en", 32'(bus.wr_en), 32'(!CHECK_EN));
        check("illegal_count", 32'(insn_count), 32'd0);
        cycle();
        idle(1'b1);
        #1 check("illegal_pulse_end", 32'(err_illegal), 32'd0);
        cycle();

        // Reset while stalled
        offer(OP_R_TYPE, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
        cycle();
        idle(1'b1);
        rst = 1'b1;
        cycle();
        idle(1'b1);
        #1 check("rst_stall_wr_en", 32'(bus.wr_en), 32'd0);
        cycle();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] imm;
            logic [6:0]  f7;
            logic [6:0]  op;
            op = ($urandom_range(9) == 0) ? 7'($urandom) : op_tab[$urandom_range(9)];
            case ($urandom_range(2))
                0:       f7 = 7'h00;
                1:       f7 = 7'h20;
                default: f7 = 7'($urandom);
            endcase
            imm = $urandom;
            if ($urandom_range(3) != 0) imm[0] = 1'b0;
            if ($urandom_range(9) < 7)
                offer(op, 3'($urandom), f7, 5'($urandom), 5'($urandom), 5'($urandom), imm,
                      $urandom_range(9) < 7);
            else
                idle($urandom_range(9) < 7);
            start = ($urandom_range(39) == 0);
            rst   = ($urandom_range(299) == 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
